// File: rtl/reg_ref_ctrl.sv
// Register-reference sequencer: walks the set bits of an accepted 0111-class word from B11 down to B0,
// one per cycle, emitting accumulator control pulses and skip/halt decisions, then a done pulse.
module reg_ref_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ir_valid,
    input  logic [15:0] ir,
    output logic        ir_ready,
    input  logic [15:0] ac_in,
    input  logic        e_in,
    output logic        clr,
    output logic        CLE,
    output logic        CMA,
    output logic        CME,
    output logic        CIR,
    output logic        CIL,
    output logic        inc,
    output logic        pc_inc,
    output logic        done,
    output logic        illegal,
    output logic        halt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] OPC_REG = 4'b0111;

    state_t      state;
    state_t      next_state;
    logic [11:0] pending;
    logic [11:0] cur;
    logic [11:0] remaining;
    logic        skip_flag;
    logic        halt_q;
    logic        illegal_q;
    logic        accept;
    logic        legal;
    logic        skip_hit;
    logic        halt_set;

    assign ir_ready  = (state == IDLE) && !halt_q;
    assign accept    = ir_valid && ir_ready;
    assign legal     = (ir[15:12] == OPC_REG);
    assign remaining = pending & ~cur;
    assign illegal   = illegal_q;
    // Halt is visible in the very cycle B0 is processed, not one cycle later.
    assign halt      = halt_q | halt_set;

    // Highest pending bit wins: later loop iterations overwrite earlier ones.
    always_comb begin
        cur = '0;
        for (int i = 0; i < 12; i++) begin
            if (pending[i]) begin
                cur    = '0;
                cur[i] = 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        clr        = 1'b0;
        CLE        = 1'b0;
        CMA        = 1'b0;
        CME        = 1'b0;
        CIR        = 1'b0;
        CIL        = 1'b0;
        inc        = 1'b0;
        pc_inc     = 1'b0;
        done       = 1'b0;
        skip_hit   = 1'b0;
        halt_set   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && legal) begin
                    next_state = (ir[11:0] == 12'h000) ? DONE : EXEC;
                end
            end
            EXEC: begin
                clr      = cur[11];
                CLE      = cur[10];
                CMA      = cur[9];
                CME      = cur[8];
                CIR      = cur[7];
                CIL      = cur[6];
                inc      = cur[5];
                halt_set = cur[0];
                skip_hit = (cur[4] && !ac_in[15])
                         | (cur[3] &&  ac_in[15])
                         | (cur[2] && (ac_in == 16'h0000))
                         | (cur[1] && !e_in);
                if (remaining == 12'h000) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                pc_inc     = skip_flag;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            skip_flag <= 1'b0;
            halt_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state     <= next_state;
            illegal_q <= accept && !legal;
            if (accept && legal) begin
                pending <= ir[11:0];
            end else if (state == EXEC) begin
                pending <= remaining;
            end
            // Several true skip tests still collapse into a single pc_inc.
            if (state == EXEC) begin
                skip_flag <= skip_flag | skip_hit;
            end else if (state == DONE) begin
                skip_flag <= 1'b0;
            end
            if (halt_set) begin
                halt_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_ref_ctrl.sv
// Bench for reg_ref_ctrl: directed cases plus random words against a bit-serial reference model,
// with a small accumulator stage in the environment that reacts to the control pulses.
module tb_reg_ref_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ir_valid;
    logic [15:0] ir;
    logic        ir_ready;
    logic [15:0] ac_in;
    logic        e_in;
    logic        clr, CLE, CMA, CME, CIR, CIL, inc;
    logic        pc_inc, done, illegal, halt;
    logic [6:0]  pulse_vec;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign pulse_vec = {clr, CLE, CMA, CME, CIR, CIL, inc};

    reg_ref_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .ir_valid (ir_valid),
        .ir       (ir),
        .ir_ready (ir_ready),
        .ac_in    (ac_in),
        .e_in     (e_in),
        .clr      (clr),
        .CLE      (CLE),
        .CMA      (CMA),
        .CME      (CME),
        .CIR      (CIR),
        .CIL      (CIL),
        .inc      (inc),
        .pc_inc   (pc_inc),
        .done     (done),
        .illegal  (illegal),
        .halt     (halt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Effect of one operate bit on the {E, AC} pair.
    function automatic logic [16:0] apply_op(input int idx, input logic [16:0] s);
        logic [16:0] r;
        r = s;
        case (idx)
            11: r[15:0] = 16'h0000;
            10: r[16]   = 1'b0;
            9:  r[15:0] = ~s[15:0];
            8:  r[16]   = ~s[16];
            7:  r       = {s[0], s[16:1]};
            6:  r       = {s[15:0], s[16]};
            5:  r[15:0] = s[15:0] + 16'd1;
            default: r = s;
        endcase
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        ir_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_pulses", 32'(pulse_vec), 32'd0);
        check("rst_ready", 32'(ir_ready), 32'd1);
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
    endtask

    // Offers one legal word; the reference walks the word's bits on its own copy of {E, AC}.
    task automatic run_word(input logic [15:0] w, input logic [15:0] ac0, input logic e0);
        int          seq[$];
        logic [16:0] s;
        logic [16:0] env;
        logic [6:0]  obs;
        logic        exp_skip;
        logic        exp_halt;
        int          k;
        s        = {e0, ac0};
        exp_skip = 1'b0;
        exp_halt = 1'b0;
        for (int i = 11; i >= 0; i--) begin
            if (w[i]) begin
                seq.push_back(i);
                if (i >= 5)      s = apply_op(i, s);
                else if (i == 4) exp_skip = exp_skip | !s[15];
                else if (i == 3) exp_skip = exp_skip | s[15];
                else if (i == 2) exp_skip = exp_skip | (s[15:0] == 16'h0000);
                else if (i == 1) exp_skip = exp_skip | !s[16];
                else             exp_halt = 1'b1;
            end
        end
        k = seq.size();
        @(negedge clk);
        ac_in    = ac0;
        e_in     = e0;
        ir       = w;
        ir_valid = 1'b1;
        check("ready_before", 32'(ir_ready), 32'd1);
        @(posedge clk);
        #1 ir_valid = 1'b0;
        ir = 16'($urandom);
        for (int c = 0; c < k; c++) begin
            @(negedge clk);
            obs = pulse_vec;
            check("pulse", 32'(obs), (seq[c] >= 5) ? (32'd1 << (seq[c] - 5)) : 32'd0);
            check("done_early", 32'(done), 32'd0);
            check("pc_inc_early", 32'(pc_inc), 32'd0);
            check("ready_busy", 32'(ir_ready), 32'd0);
            if (seq[c] == 0) check("halt_set", 32'(halt), 32'd1);
            @(posedge clk);
            #1;
            env = {e_in, ac_in};
            for (int j = 0; j < 7; j++) begin
                if (obs[j]) env = apply_op(j + 5, env);
            end
            {e_in, ac_in} = env;
        end
        @(negedge clk);
        check("done", 32'(done), 32'd1);
        check("pc_inc", 32'(pc_inc), 32'(exp_skip));
        check("pulses_in_done", 32'(pulse_vec), 32'd0);
        check("illegal_legal", 32'(illegal), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("done_after", 32'(done), 32'd0);
        check("ready_after", 32'(ir_ready), 32'(!exp_halt));
        check("halt_after", 32'(halt), 32'(exp_halt));
    endtask

    task automatic run_illegal(input logic [15:0] w);
        @(negedge clk);
        ir       = w;
        ir_valid = 1'b1;
        @(posedge clk);
        #1 ir_valid = 1'b0;
        @(negedge clk);
        check("illegal_pulse", 32'(illegal), 32'd1);
        check("illegal_no_pulse", 32'(pulse_vec), 32'd0);
        check("illegal_no_done", 32'(done), 32'd0);
        check("illegal_ready", 32'(ir_ready), 32'd1);
        @(negedge clk);
        check("illegal_one_cycle", 32'(illegal), 32'd0);
        check("illegal_no_done2", 32'(done), 32'd0);
        check("illegal_no_pulse2", 32'(pulse_vec), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        ir_valid = 1'b0;
        ir       = 16'h0000;
        ac_in    = 16'h0000;
        e_in     = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        run_word(16'h7800, 16'h1234, 1'b1);
        run_word(16'h7A20, 16'h5A5A, 1'b0);
        check("ac_after_7a20", 32'(ac_in), 32'h0000);
        run_word(16'h7004, 16'h0000, 1'b0);
        run_word(16'h7004, 16'h0001, 1'b0);
        run_word(16'h7000, 16'h0000, 1'b1);
        run_word(16'h701E, 16'h8000, 1'b0);
        run_word(16'h70C2, 16'h8001, 1'b1);
        run_illegal(16'h3000);
        run_illegal(16'hF7FF);

        run_word(16'h7001, 16'h0000, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ir       = 16'h7800;
            ir_valid = 1'b1;
            check("halted_ready", 32'(ir_ready), 32'd0);
            check("halted_pulse", 32'(pulse_vec), 32'd0);
            check("halted_done", 32'(done), 32'd0);
            check("halted_flag", 32'(halt), 32'd1);
        end
        do_reset();

        // Reset lands on the edge that ends the CLE cycle.
        @(negedge clk);
        ir       = 16'h7FE0;
        ir_valid = 1'b1;
        @(posedge clk);
        #1 ir_valid = 1'b0;
        @(negedge clk);
        check("abort_clr", 32'(pulse_vec), 32'h40);
        @(negedge clk);
        check("abort_cle", 32'(pulse_vec), 32'h20);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("abort_pulses", 32'(pulse_vec), 32'd0);
            check("abort_done", 32'(done), 32'd0);
            check("abort_ready", 32'(ir_ready), 32'd1);
        end

        for (int n = 0; n < 40; n++) begin
            logic [15:0] w;
            logic [15:0] a;
            logic [3:0]  opc;
            logic [11:0] bits;
            bits = 12'($urandom);
            if ($urandom_range(0, 5) != 0) bits[0] = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                opc = 4'($urandom_range(0, 15));
                if (opc == 4'h7) opc = 4'h0;
            end else begin
                opc = 4'h7;
            end
            case ($urandom_range(0, 3))
                0:       a = 16'h0000;
                1:       a = 16'h8000;
                default: a = 16'($urandom);
            endcase
            w = {opc, bits};
            if (opc == 4'h7) run_word(w, a, 1'($urandom));
            else             run_illegal(w);
            if (halt) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
